// File: rtl/text_pkg.sv
// Shared types and constants for the OLED text buffer writer.
// TEXT_SCROLL_EN adds the SCROLL state used on buffer overflow.
package text_pkg;

   localparam int unsigned COLS        = 16;
   localparam int unsigned ROWS        = 4;
   localparam int unsigned DEPTH       = COLS * ROWS;
   localparam int unsigned ADDR_W      = 6;
   localparam int unsigned COL_W       = 4;
   localparam int unsigned ROW_W       = 2;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned SCROLL_KEEP = (ROWS - 1) * COLS;

   localparam logic [DATA_W-1:0] BLANK    = 8'h20;
   localparam logic [DATA_W-1:0] CH_LF    = 8'h0A;
   localparam logic [DATA_W-1:0] CH_CR    = 8'h0D;
   localparam logic [DATA_W-1:0] CH_BS    = 8'h08;
   localparam logic [DATA_W-1:0] CH_FF    = 8'h0C;
   localparam logic [DATA_W-1:0] PRINT_LO = 8'h20;
   localparam logic [DATA_W-1:0] PRINT_HI = 8'h7E;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_IDLE   = 2'd1
`ifdef TEXT_SCROLL_EN
      ,ST_SCROLL = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/text_buffer_writer_if.sv
// Byte-stream, display-read and status signals of the text buffer writer.
interface text_buffer_writer_if;
   import text_pkg::*;

   logic [DATA_W-1:0] inData;
   logic              inValid;
   logic              inReady;
   logic [ADDR_W-1:0] charAddress;
   logic [DATA_W-1:0] charOutput;
   logic [ADDR_W-1:0] cursor;
   logic              busy;

   modport master (
      output inData, inValid, charAddress,
      input  inReady, charOutput, cursor, busy
   );

   modport slave (
      input  inData, inValid, charAddress,
      output inReady, charOutput, cursor, busy
   );

endinterface

// File: rtl/char_ram.sv
// 64x8 character RAM: one write port, registered display read (old data on collision).
// With TEXT_SCROLL_EN a combinational read port feeds the scroll copy.
module char_ram
   import text_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
`ifdef TEXT_SCROLL_EN
   ,input  logic [ADDR_W-1:0] i_caddr
   ,output logic [DATA_W-1:0] o_cdata
`endif
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) o_rdata <= BLANK;
      else       o_rdata <= r_mem[i_raddr];
   end

`ifdef TEXT_SCROLL_EN
   assign o_cdata = r_mem[i_caddr];
`endif

endmodule

// File: rtl/text_buffer_writer.sv
// Cursor-driven producer for the OLED text engine's 16x4 character buffer.
// Define TEXT_SCROLL_EN to scroll up one row on overflow instead of wrapping to 0.
module text_buffer_writer
   import text_pkg::*;
(
   input logic                clk,
   input logic                reset,
   text_buffer_writer_if.slave bus
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_cursor;
   logic              r_ready;
   logic              r_busy;

   logic              w_accept;
   logic              w_printable;
   logic [ROW_W-1:0]  w_row;
   logic [ADDR_W-1:0] w_cursor_dec;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
`ifdef TEXT_SCROLL_EN
   logic [ADDR_W-1:0] w_copy_addr;
   logic [DATA_W-1:0] w_copy_data;
   assign w_copy_addr = ADDR_W'(r_cnt + ADDR_W'(COLS));
`endif

   assign w_accept     = bus.inValid && r_ready;
   assign w_printable  = (bus.inData >= PRINT_LO) && (bus.inData <= PRINT_HI);
   assign w_row        = r_cursor[ADDR_W-1:COL_W];
   assign w_cursor_dec = (r_cursor == '0) ? '0 : ADDR_W'(r_cursor - ADDR_W'(1));

   assign bus.inReady = r_ready;
   assign bus.busy    = r_busy;
   assign bus.cursor  = r_cursor;

   // RAM write port: blank fill, accepted characters, backspace erase, scroll copy
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_cnt;
      w_wdata = BLANK;
      case (r_state)
         ST_CLEAR: w_we = 1'b1;
         ST_IDLE: begin
            if (w_accept && w_printable) begin
               w_we    = 1'b1;
               w_waddr = r_cursor;
               w_wdata = bus.inData;
            end else if (w_accept && (bus.inData == CH_BS)) begin
               w_we    = 1'b1;
               w_waddr = w_cursor_dec;
            end
         end
`ifdef TEXT_SCROLL_EN
         ST_SCROLL: begin
            w_we = 1'b1;
            if (r_cnt < ADDR_W'(SCROLL_KEEP)) w_wdata = w_copy_data;
         end
`endif
         default: w_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_CLEAR;
         r_cnt    <= '0;
         r_cursor <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b1;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_cnt <= ADDR_W'(r_cnt + ADDR_W'(1));
               if (r_cnt == LAST_ADDR) begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_cursor <= '0;
                  r_ready  <= 1'b1;
                  r_busy   <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_printable) begin
`ifdef TEXT_SCROLL_EN
                     if (r_cursor == LAST_ADDR) begin
                        r_state  <= ST_SCROLL;
                        r_cnt    <= '0;
                        r_cursor <= ADDR_W'(SCROLL_KEEP);
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                     end else
`endif
                     r_cursor <= ADDR_W'(r_cursor + ADDR_W'(1));
                  end else begin
                     case (bus.inData)
                        CH_LF: begin
`ifdef TEXT_SCROLL_EN
                           if (w_row == ROW_W'(ROWS - 1)) begin
                              r_state  <= ST_SCROLL;
                              r_cnt    <= '0;
                              r_cursor <= ADDR_W'(SCROLL_KEEP);
                              r_ready  <= 1'b0;
                              r_busy   <= 1'b1;
                           end else
`endif
                           r_cursor <= {ROW_W'(w_row + ROW_W'(1)), COL_W'(0)};
                        end
                        CH_CR: r_cursor <= {w_row, COL_W'(0)};
                        CH_BS: r_cursor <= w_cursor_dec;
                        CH_FF: begin
                           r_state <= ST_CLEAR;
                           r_cnt   <= '0;
                           r_ready <= 1'b0;
                           r_busy  <= 1'b1;
                        end
                        default: r_cursor <= r_cursor;
                     endcase
                  end
               end
            end
`ifdef TEXT_SCROLL_EN
            ST_SCROLL: begin
               r_cnt <= ADDR_W'(r_cnt + ADDR_W'(1));
               if (r_cnt == LAST_ADDR) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
`endif
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

   char_ram u_ram (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (bus.charAddress),
      .o_rdata (bus.charOutput)
`ifdef TEXT_SCROLL_EN
      ,.i_caddr (w_copy_addr)
      ,.o_cdata (w_copy_data)
`endif
   );

endmodule

// File: tb/tb_text_buffer_writer.sv
// Random and directed stimulus for text_buffer_writer against a character-grid model.
// Honors TEXT_SCROLL_EN the same way as the design.
module tb_text_buffer_writer;

   localparam int COLS = 16;
   localparam int ROWS = 4;
   localparam int NCH  = COLS * ROWS;
`ifdef TEXT_SCROLL_EN
   localparam bit SCROLL_EN = 1'b1;
`else
   localparam bit SCROLL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   text_buffer_writer_if u_if ();

   text_buffer_writer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [7:0]  m_mem [NCH];
   int          m_cur;
   logic [7:0]  last_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) m_mem[i] = 8'h20;
      m_cur = 0;
   endtask

   // Applies one accepted byte to the grid; len is the resulting not-ready period
   task automatic model_apply(input logic [7:0] b, output int len);
      int row;
      bit ovf;
      len = 0;
      ovf = 1'b0;
      row = m_cur / COLS;
      if (b >= 8'h20 && b <= 8'h7E) begin
         m_mem[m_cur] = b;
         if (m_cur == NCH - 1) ovf = 1'b1;
         else m_cur++;
      end else if (b == 8'h0A) begin
         if (row == ROWS - 1) ovf = 1'b1;
         else m_cur = (row + 1) * COLS;
      end else if (b == 8'h0D) begin
         m_cur = row * COLS;
      end else if (b == 8'h08) begin
         if (m_cur > 0) m_cur--;
         m_mem[m_cur] = 8'h20;
      end else if (b == 8'h0C) begin
         model_clear();
         len = NCH;
      end
      if (ovf) begin
         if (SCROLL_EN) begin
            for (int i = 0; i < NCH - COLS; i++) m_mem[i] = m_mem[i + COLS];
            for (int i = NCH - COLS; i < NCH; i++) m_mem[i] = 8'h20;
            m_cur = NCH - COLS;
            len = NCH;
         end else begin
            m_cur = 0;
         end
      end
   endtask

   task automatic wait_ready(input int exp_len);
      int n = 0;
      check("busy_during", u_if.busy, 1'b1);
      while (!u_if.inReady && n < 300) begin
         n++;
         tick();
      end
      check("notready_len", n, exp_len);
      check("busy_after", u_if.busy, 1'b0);
   endtask

   task automatic send(input logic [7:0] b);
      int len;
      check("ready_before", u_if.inReady, 1'b1);
      u_if.inData  = b;
      u_if.inValid = 1'b1;
      tick();
      u_if.inValid = 1'b0;
      last_rd = u_if.charOutput;
      model_apply(b, len);
      if (len > 0) wait_ready(len);
      check("cursor", u_if.cursor, 32'(m_cur));
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < NCH; i++) begin
         u_if.charAddress = 6'(i);
         tick();
         check(tag, u_if.charOutput, m_mem[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int r;
      reset = 1'b1;
      u_if.inData = 8'h00;
      u_if.inValid = 1'b0;
      u_if.charAddress = 6'd0;
      model_clear();
      repeat (3) tick();
      check("rst_ready", u_if.inReady, 1'b0);
      check("rst_busy", u_if.busy, 1'b1);
      check("rst_cursor", u_if.cursor, 6'd0);
      check("rst_charout", u_if.charOutput, 8'h20);
      reset = 1'b0;
      wait_ready(NCH);
      read_all("init_mem");
      check("init_cursor", u_if.cursor, 6'd0);

      // "Hi" back-to-back, reading address 0 while it is written
      u_if.charAddress = 6'd0;
      send(8'h48);
      check("collide_old", last_rd, 8'h20);
      send(8'h69);
      check("read_after", last_rd, 8'h48);
      check("hi_cursor", u_if.cursor, 6'd2);
      read_all("hi_mem");

      // Line control codes
      send(8'h0C);
      send(8'h41); send(8'h42); send(8'h0A);
      check("lf_cursor", u_if.cursor, 6'd16);
      send(8'h43); send(8'h0D);
      check("cr_cursor", u_if.cursor, 6'd16);
      send(8'h08);
      check("bs_cursor", u_if.cursor, 6'd15);
      read_all("bs_mem");
      send(8'h0D); send(8'h08);
      check("bs_zero", u_if.cursor, 6'd0);

      // Fill all 64 cells to force overflow
      send(8'h0C);
      for (int i = 0; i < NCH; i++) send(8'(8'h21 + i));
      check("ovf_cursor", u_if.cursor, SCROLL_EN ? 6'd48 : 6'd0);
      read_all("ovf_mem");
      send(8'h7A);
      read_all("ovf_next");

      // FF mid-text, then reset in the middle of the clear
      send(8'h55); send(8'h56);
      check("ready_ff", u_if.inReady, 1'b1);
      u_if.inData = 8'h0C;
      u_if.inValid = 1'b1;
      tick();
      u_if.inValid = 1'b0;
      repeat (20) tick();
      reset = 1'b1;
      #1;
      check("abort_ready", u_if.inReady, 1'b0);
      check("abort_busy", u_if.busy, 1'b1);
      check("abort_cursor", u_if.cursor, 6'd0);
      check("abort_charout", u_if.charOutput, 8'h20);
      tick();
      reset = 1'b0;
      model_clear();
      wait_ready(NCH);
      read_all("abort_mem");

      // Randomized byte stream
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70)      b = 8'($urandom_range(32, 126));
         else if (r < 78) b = 8'h0A;
         else if (r < 84) b = 8'h0D;
         else if (r < 92) b = 8'h08;
         else if (r < 94) b = 8'h0C;
         else             b = 8'($urandom_range(0, 255));
         send(b);
         if (k % 100 == 99) read_all("rand_mem");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
